// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and response-pipeline beat type for mem_ctrl.
// Imported by the request/response interface, the read pipeline and the top.
package mem_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2,
    WR       = 2'd3
  } state_t;

  typedef struct packed {
    logic vld;
    logic last;
  } beat_t;

  // RAM address space wraps, so 0xFF steps to 0x00
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between a requester (master) and mem_ctrl (slave).
// Ready/valid on requests only; responses carry no backpressure.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len,
    input  req_ready, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len,
    output req_ready, rsp_valid, rsp_data, rsp_last, busy
  );

endinterface

// File: rtl/mem_ctrl_rdpipe.sv
// Valid/last shift pipeline (RD_LAT+1 deep) aligning RAM read data into a registered rsp_data.
// Latency RD_LAT+1 from issue to rsp_valid; no backpressure, every beat is presented once.
module mem_ctrl_rdpipe
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_vld,
  input  logic              issue_last,
  input  logic              wr_ack,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              rsp_valid,
  output logic              rsp_last,
  output logic [DATA_W-1:0] rsp_data
);

  beat_t            issue_beat;
  beat_t [RD_LAT:0] pipe_q;
  logic             ack_q;

  assign issue_beat = '{vld: issue_vld, last: issue_last};

  // Stage RD_LAT-1 lines up with ram_dout; the final stage lines up with rsp_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q   <= '0;
      ack_q    <= 1'b0;
      rsp_data <= '0;
    end else begin
      pipe_q <= {pipe_q[RD_LAT-1:0], issue_beat};
      ack_q  <= wr_ack;
      if (pipe_q[RD_LAT-1].vld) begin
        rsp_data <= ram_dout;
      end else if (wr_ack) begin
        rsp_data <= '0;
      end
    end
  end

  assign rsp_valid = pipe_q[RD_LAT].vld | ack_q;
  assign rsp_last  = (pipe_q[RD_LAT].vld & pipe_q[RD_LAT].last) | ack_q;

endmodule

// File: rtl/mem_ctrl.sv
// Single-port RAM controller: one-word writes and read bursts (burst length honoured when MEM_CTRL_BURST_EN is defined).
// Accepts only in IDLE (req_ready), first read beat RD_LAT+2 cycles after accept; responses are never stalled.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adrs,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] req_len_eff;
  logic             accept;
  logic             issue_vld;
  logic             issue_last;
  logic             wr_ack;
  logic             rsp_valid_i;
  logic             rsp_last_i;
  logic [DATA_W-1:0] rsp_data_i;

`ifdef MEM_CTRL_BURST_EN
  assign req_len_eff = bus.req_len;
`else
  logic [LEN_W-1:0] unused_req_len;
  assign unused_req_len = bus.req_len;
  assign req_len_eff    = '0;
`endif

  assign accept     = bus.req_valid && (state == IDLE);
  assign issue_vld  = (state == RD_ISSUE);
  assign issue_last = issue_vld && (cnt_q == len_q);
  assign wr_ack     = (state == WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ram_adrs <= '0;
      ram_din  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ram_adrs <= bus.req_addr;
        len_q    <= req_len_eff;
        cnt_q    <= '0;
        if (bus.req_we) begin
          ram_din <= bus.req_wdata;
        end
      end else if (issue_vld && !issue_last) begin
        // Final burst address is held through drain and idle
        ram_adrs <= addr_next(ram_adrs);
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    ram_rw        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          state_nxt = bus.req_we ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (issue_last) begin
          state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (rsp_valid_i && rsp_last_i) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        ram_rw    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_ctrl_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (issue_vld),
    .issue_last (issue_last),
    .wr_ack     (wr_ack),
    .ram_dout   (ram_dout),
    .rsp_valid  (rsp_valid_i),
    .rsp_last   (rsp_last_i),
    .rsp_data   (rsp_data_i)
  );

  assign bus.rsp_valid = rsp_valid_i;
  assign bus.rsp_last  = rsp_last_i;
  assign bus.rsp_data  = rsp_data_i;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency RAM model and an expected-memory scoreboard.
// Expectations follow MEM_CTRL_BURST_EN when it is defined for the build.
module tb_mem_ctrl;

`ifdef MEM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ram_rw;
  logic [7:0]  ram_adrs;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] ram_mem [256];
  logic [15:0] exp_mem [256];

  int n_assert;
  int n_fail;

  mem_ctrl_if bus ();

  mem_ctrl #(
    .RD_LAT (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_rw   (ram_rw),
    .ram_adrs (ram_adrs),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: address sampled at an edge, data valid the following cycle
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] <= 16'h5000 + 16'(i);
  end

  always @(posedge clk) begin
    if (ram_rw) ram_mem[ram_adrs] <= ram_din;
    ram_dout <= ram_mem[ram_adrs];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Presents one request for one cycle; returns in the cycle after the accept edge
  task automatic send(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                      input logic [2:0] len);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_len   = len;
    cyc();
    bus.req_valid = 1'b0;
    if (we) exp_mem[addr] = wd;
  endtask

  task automatic run_read(input logic [7:0] addr, input logic [2:0] len, input string tag);
    int n;
    logic [7:0] ea;
    logic [7:0] da;
    bit ev;
    n = BURST ? int'(len) + 1 : 1;
    send(1'b0, addr, 16'h0, len);
    for (int c = 1; c <= n + 3; c++) begin
      ea = addr + 8'(((c <= n) ? c : n) - 1);
      ev = (c >= 3) && (c <= n + 2);
      check($sformatf("%s_c%0d_adrs", tag, c), 32'(ram_adrs), 32'(ea));
      check($sformatf("%s_c%0d_rw", tag, c), 32'(ram_rw), 32'(0));
      check($sformatf("%s_c%0d_busy", tag, c), 32'(bus.busy), 32'(c <= n + 2));
      check($sformatf("%s_c%0d_vld", tag, c), 32'(bus.rsp_valid), 32'(ev));
      if (ev) begin
        da = addr + 8'(c - 3);
        check($sformatf("%s_c%0d_data", tag, c), 32'(bus.rsp_data), 32'(exp_mem[da]));
        check($sformatf("%s_c%0d_last", tag, c), 32'(bus.rsp_last), 32'(c == n + 2));
      end
      cyc();
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h5000 + 16'(i);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 16'h0000;
    bus.req_len   = 3'd0;

    // Reset state
    cyc();
    cyc();
    check("rst_ready", 32'(bus.req_ready), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_vld", 32'(bus.rsp_valid), 32'(0));
    check("rst_last", 32'(bus.rsp_last), 32'(0));
    check("rst_data", 32'(bus.rsp_data), 32'(0));
    check("rst_rw", 32'(ram_rw), 32'(0));
    check("rst_adrs", 32'(ram_adrs), 32'(0));
    check("rst_din", 32'(ram_din), 32'(0));
    rst = 1'b0;
    cyc();

    // Write 0x0FFF to 0x03, then read it back
    send(1'b1, 8'h03, 16'h0FFF, 3'd0);
    check("wr_rw", 32'(ram_rw), 32'(1));
    check("wr_adrs", 32'(ram_adrs), 32'h03);
    check("wr_din", 32'(ram_din), 32'h0FFF);
    check("wr_busy", 32'(bus.busy), 32'(1));
    check("wr_ready", 32'(bus.req_ready), 32'(0));
    check("wr_vld0", 32'(bus.rsp_valid), 32'(0));
    cyc();
    check("wack_vld", 32'(bus.rsp_valid), 32'(1));
    check("wack_last", 32'(bus.rsp_last), 32'(1));
    check("wack_data", 32'(bus.rsp_data), 32'(0));
    check("wack_rw", 32'(ram_rw), 32'(0));
    check("wack_ready", 32'(bus.req_ready), 32'(1));
    run_read(8'h03, 3'd0, "rd03");
    check("hold_din", 32'(ram_din), 32'h0FFF);

    // Pre-load 0x10..0x17, then an 8-word burst
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 8'(16 + i), 16'hA000 + 16'(i), 3'd0);
      cyc();
    end
    run_read(8'h10, 3'd7, "burst10");

    // Address wrap 0xFE -> 0x01
    run_read(8'hFE, 3'd3, "wrapFE");

    // req_len=5 from 0x20
    run_read(8'h20, 3'd5, "len5");

    // Reset on the 2nd beat of an 8-word burst
    send(1'b0, 8'h10, 16'h0, 3'd7);
    cyc();
    cyc();
    check("abort_b1_vld", 32'(bus.rsp_valid), 32'(1));
    check("abort_b1_data", 32'(bus.rsp_data), 32'hA000);
    cyc();
    check("abort_b2_vld", 32'(bus.rsp_valid), 32'(BURST));
    if (BURST) check("abort_b2_data", 32'(bus.rsp_data), 32'hA001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_ready", 32'(bus.req_ready), 32'(1));
    check("abort_rw", 32'(ram_rw), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_vld", 32'(bus.rsp_valid), 32'(0));
    check("abort_data", 32'(bus.rsp_data), 32'(0));
    check("abort_adrs", 32'(ram_adrs), 32'(0));
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("abort_quiet%0d", i), 32'(bus.rsp_valid), 32'(0));
    end

    // req_valid held high while busy: one transaction, next accepted only in IDLE
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h30;
    bus.req_len   = 3'd0;
    cyc();
    check("hold_c1_busy", 32'(bus.busy), 32'(1));
    check("hold_c1_ready", 32'(bus.req_ready), 32'(0));
    check("hold_c1_adrs", 32'(ram_adrs), 32'h30);
    bus.req_addr = 8'h55;
    cyc();
    check("hold_c2_adrs", 32'(ram_adrs), 32'h30);
    check("hold_c2_ready", 32'(bus.req_ready), 32'(0));
    cyc();
    check("hold_c3_vld", 32'(bus.rsp_valid), 32'(1));
    check("hold_c3_data", 32'(bus.rsp_data), 32'h5030);
    check("hold_c3_last", 32'(bus.rsp_last), 32'(1));
    check("hold_c3_ready", 32'(bus.req_ready), 32'(0));
    cyc();
    check("hold_c4_ready", 32'(bus.req_ready), 32'(1));
    check("hold_c4_busy", 32'(bus.busy), 32'(0));
    check("hold_c4_adrs", 32'(ram_adrs), 32'h30);
    check("hold_c4_vld", 32'(bus.rsp_valid), 32'(0));
    bus.req_addr = 8'h31;
    cyc();
    bus.req_valid = 1'b0;
    check("b2b_c1_busy", 32'(bus.busy), 32'(1));
    check("b2b_c1_adrs", 32'(ram_adrs), 32'h31);
    cyc();
    check("b2b_c2_vld", 32'(bus.rsp_valid), 32'(0));
    cyc();
    check("b2b_c3_vld", 32'(bus.rsp_valid), 32'(1));
    check("b2b_c3_data", 32'(bus.rsp_data), 32'h5031);
    check("b2b_c3_last", 32'(bus.rsp_last), 32'(1));
    cyc();
    check("b2b_c4_busy", 32'(bus.busy), 32'(0));
    check("b2b_c4_vld", 32'(bus.rsp_valid), 32'(0));
    cyc();
    check("b2b_c5_busy", 32'(bus.busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RD_LAT, default 1, RAM read latency in cycles from address-present cycle to dout-valid cycle (legal 1..3).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  controller accepts request this cycle.
REQ-006 req_we  in  1  1 = single-word write, 0 = read burst.
REQ-007 req_addr  in  8  start address.
REQ-008 req_wdata  in  16  write data.
REQ-009 req_len  in  3  read burst length minus one (1..8 words); ignored for writes.
REQ-010 rsp_valid  out  1  read word or write ack valid.
REQ-011 rsp_data  out  16  read data; 0 on write ack.
REQ-012 rsp_last  out  1  final response of the transaction.
REQ-013 busy  out  1  transaction in flight.
REQ-014 ram_rw  out  1  RAM rw: 1 = write, 0 = read.
REQ-015 ram_adrs  out  8  RAM address.
REQ-016 ram_din  out  16  RAM write data.
REQ-017 ram_dout  in  16  RAM read data.

Function
REQ-018 FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR; req_ready = 1 only in IDLE; busy = not IDLE.
REQ-019 Accept on the rising edge where req_valid and req_ready are both high; sample req_we, req_addr, req_wdata, req_len there.
REQ-020 Write: IDLE->WR; the cycle after accept drives ram_rw=1, ram_adrs=addr, ram_din=wdata; the next cycle drives rsp_valid=1, rsp_last=1, rsp_data=0 and returns to IDLE.
REQ-021 Read: IDLE->RD_ISSUE; ram_rw=0; addresses addr, addr+1, ... are presented on consecutive cycles, one per cycle, req_len+1 in total; then ->RD_DRAIN.
REQ-022 Each ram_dout word is registered into rsp_data; for RD_LAT=1 the first rsp_valid is the 3rd cycle after the accept edge; words follow back-to-back in address order.
REQ-023 rsp_last is high with the final word only; the FSM returns to IDLE in the cycle after the rsp_last cycle.
REQ-024 Address increment is modulo 256; 0xFF is followed by 0x00.
REQ-025 No response backpressure; the consumer takes every rsp_valid beat.
REQ-026 req_valid in a non-IDLE state is ignored and not queued.
REQ-027 Outside WR, ram_rw=0 and ram_din holds its last value; in IDLE, ram_adrs holds its last value.
REQ-028 Response-valid/last tracking uses an (RD_LAT+1)-deep shift pipeline, so any RD_LAT gives gap-free bursts.

Reset
REQ-029 rst forces IDLE; req_ready=1 in IDLE; busy=0, rsp_valid=0, rsp_last=0, rsp_data=0, ram_rw=0, ram_adrs=0, ram_din=0, pipeline cleared.
REQ-030 rst during any transaction aborts it; no further rsp_valid for that transaction; ram_rw=0 in the cycle after reset.

Configuration
REQ-031 Macro MEM_CTRL_BURST_EN defined: req_len is honoured per REQ-021.
REQ-032 Macro MEM_CTRL_BURST_EN undefined: req_len is ignored; every read is one word with rsp_last=1.

Structure
REQ-033 Package mem_ctrl_pkg holds ADDR_W=8, DATA_W=16, LEN_W=3 and the FSM state typedef.
REQ-034 Sub-module mem_ctrl_rdpipe implements the RD_LAT valid/last shift pipeline and the rsp_data capture register.

Verification
REQ-035 Write 0x0FFF to address 0x03, then read 1 word from 0x03 -> write ack (rsp_last=1, rsp_data=0), then rsp_data=0x0FFF with rsp_last=1.
REQ-036 With BURST_EN, pre-load 0x10..0x17 with 0xA000+i and read req_len=7 from 0x10 -> 8 consecutive rsp_valid beats 0xA000..0xA007; rsp_last on the 8th only.
REQ-037 Read req_len=3 from 0xFE -> addresses 0xFE, 0xFF, 0x00, 0x01 appear on ram_adrs on consecutive cycles.
REQ-038 Assert rst on the 2nd beat of an 8-word burst -> no further rsp_valid; req_ready=1 and ram_rw=0 the cycle after reset.
REQ-039 Hold req_valid high while busy -> exactly one transaction is performed; a back-to-back request is accepted only after return to IDLE.
REQ-040 Without BURST_EN, read req_len=5 from 0x20 -> one beat with rsp_last=1.
